// File: rtl/ex_if.sv
// Signal bundle between the ID/EX register, the WB stage and the EX/MEM register.
// The execute stage takes the slave side.
interface ex_if;
  logic        start_i;
  logic        RegWrite_i;
  logic        MemtoReg_i;
  logic        MemRead_i;
  logic        MemWrite_i;
  logic        ALUSrc_i;
  logic [1:0]  ALUOp_i;
  logic [31:0] reg1Data_i;
  logic [31:0] reg2Data_i;
  logic [4:0]  rs1_i;
  logic [4:0]  rs2_i;
  logic [4:0]  rd_i;
  logic [9:0]  funct_i;
  logic [31:0] imm_i;
  logic        wbRegWrite_i;
  logic [4:0]  wbRd_i;
  logic [31:0] wbData_i;

  logic        start_o;
  logic        RegWrite_o;
  logic        MemtoReg_o;
  logic        MemRead_o;
  logic        MemWrite_o;
  logic [31:0] ALUResult_o;
  logic [31:0] memWriteData_o;
  logic [4:0]  rd_o;
  logic [1:0]  fwdA_o;
  logic [1:0]  fwdB_o;

  modport slave (
    input  start_i, RegWrite_i, MemtoReg_i, MemRead_i, MemWrite_i, ALUSrc_i, ALUOp_i,
           reg1Data_i, reg2Data_i, rs1_i, rs2_i, rd_i, funct_i, imm_i,
           wbRegWrite_i, wbRd_i, wbData_i,
    output start_o, RegWrite_o, MemtoReg_o, MemRead_o, MemWrite_o, ALUResult_o,
           memWriteData_o, rd_o, fwdA_o, fwdB_o
  );

  modport master (
    output start_i, RegWrite_i, MemtoReg_i, MemRead_i, MemWrite_i, ALUSrc_i, ALUOp_i,
           reg1Data_i, reg2Data_i, rs1_i, rs2_i, rd_i, funct_i, imm_i,
           wbRegWrite_i, wbRd_i, wbData_i,
    input  start_o, RegWrite_o, MemtoReg_o, MemRead_o, MemWrite_o, ALUResult_o,
           memWriteData_o, rd_o, fwdA_o, fwdB_o
  );
endinterface

// File: rtl/ex_stage.sv
// Execute stage: operand forwarding, ALU decode and 32-bit ALU, plus the EX/MEM register.
// The EX/MEM register outputs double as the nearest forwarding source.
module ex_stage #(
  parameter bit FWD_EN = 1'b1
) (
  input  logic clk_i,
  input  logic rst_i,
  ex_if.slave  bus
);

  logic [4:0]  rs_id   [2];
  logic [31:0] rf_data [2];
  logic [31:0] op_a;
  logic [31:0] fwd_b;
  logic [31:0] op_b;
  logic [31:0] alu_result;

  assign rs_id[0]   = bus.rs1_i;
  assign rs_id[1]   = bus.rs2_i;
  assign rf_data[0] = bus.reg1Data_i;
  assign rf_data[1] = bus.reg2Data_i;

  // Operand 0 is A, operand 1 is B; the EX/MEM producer is younger so it beats WB.
  for (genvar gi = 0; gi < 2; gi++) begin : g_fwd
    logic [1:0]  sel;
    logic [31:0] val;

    always_comb begin
      sel = 2'b00;
      if (FWD_EN && bus.RegWrite_o && (bus.rd_o != 5'd0) && (bus.rd_o == rs_id[gi])) begin
        sel = 2'b10;
      end else if (FWD_EN && bus.wbRegWrite_i && (bus.wbRd_i != 5'd0) &&
                   (bus.wbRd_i == rs_id[gi])) begin
        sel = 2'b01;
      end
    end

    always_comb begin
      val = rf_data[gi];
      case (sel)
        2'b10:   val = bus.ALUResult_o;
        2'b01:   val = bus.wbData_i;
        default: val = rf_data[gi];
      endcase
    end
  end

  assign bus.fwdA_o = g_fwd[0].sel;
  assign bus.fwdB_o = g_fwd[1].sel;
  assign op_a       = g_fwd[0].val;
  assign fwd_b      = g_fwd[1].val;
  assign op_b       = bus.ALUSrc_i ? bus.imm_i : fwd_b;

  always_comb begin
    alu_result = 32'd0;
    case (bus.ALUOp_i)
      2'b00: alu_result = op_a + op_b;
      2'b01: alu_result = op_a - op_b;
      2'b10: begin
        case (bus.funct_i)
          10'b0000000_111: alu_result = op_a & op_b;
          10'b0000000_100: alu_result = op_a ^ op_b;
          10'b0000000_001: alu_result = op_a << op_b[4:0];
          10'b0000000_000: alu_result = op_a + op_b;
          10'b0100000_000: alu_result = op_a - op_b;
          10'b0000001_000: alu_result = op_a * op_b;
          default:         alu_result = 32'd0;
        endcase
      end
      2'b11: begin
        // I-type decodes on funct3 only; srai shifts by the immediate, not opB.
        case (bus.funct_i[2:0])
          3'b000:  alu_result = op_a + op_b;
          3'b101:  alu_result = 32'($signed(op_a) >>> bus.imm_i[4:0]);
          default: alu_result = 32'd0;
        endcase
      end
      default: alu_result = 32'd0;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      bus.start_o        <= 1'b0;
      bus.RegWrite_o     <= 1'b0;
      bus.MemtoReg_o     <= 1'b0;
      bus.MemRead_o      <= 1'b0;
      bus.MemWrite_o     <= 1'b0;
      bus.ALUResult_o    <= 32'd0;
      bus.memWriteData_o <= 32'd0;
      bus.rd_o           <= 5'd0;
    end else if (bus.start_i) begin
      bus.start_o        <= 1'b1;
      bus.RegWrite_o     <= bus.RegWrite_i;
      bus.MemtoReg_o     <= bus.MemtoReg_i;
      bus.MemRead_o      <= bus.MemRead_i;
      bus.MemWrite_o     <= bus.MemWrite_i;
      bus.ALUResult_o    <= alu_result;
      bus.memWriteData_o <= fwd_b;
      bus.rd_o           <= bus.rd_i;
    end
  end

endmodule

// File: tb/tb_ex_stage.sv
// Bench for ex_stage: directed scenarios plus randomized traffic checked against a
// behavioural model of the EX/MEM register; a FWD_EN=0 copy shadows the same inputs.
module tb_ex_stage;
  logic clk;
  logic rst;
  int   tests_run;
  int   tests_failed;

  ex_if bus0 ();
  ex_if bus1 ();

  ex_stage #(.FWD_EN(1'b1)) dut (.clk_i(clk), .rst_i(rst), .bus(bus0));
  ex_stage #(.FWD_EN(1'b0)) dut_nofwd (.clk_i(clk), .rst_i(rst), .bus(bus1));

  assign bus1.start_i      = bus0.start_i;
  assign bus1.RegWrite_i   = bus0.RegWrite_i;
  assign bus1.MemtoReg_i   = bus0.MemtoReg_i;
  assign bus1.MemRead_i    = bus0.MemRead_i;
  assign bus1.MemWrite_i   = bus0.MemWrite_i;
  assign bus1.ALUSrc_i     = bus0.ALUSrc_i;
  assign bus1.ALUOp_i      = bus0.ALUOp_i;
  assign bus1.reg1Data_i   = bus0.reg1Data_i;
  assign bus1.reg2Data_i   = bus0.reg2Data_i;
  assign bus1.rs1_i        = bus0.rs1_i;
  assign bus1.rs2_i        = bus0.rs2_i;
  assign bus1.rd_i         = bus0.rd_i;
  assign bus1.funct_i      = bus0.funct_i;
  assign bus1.imm_i        = bus0.imm_i;
  assign bus1.wbRegWrite_i = bus0.wbRegWrite_i;
  assign bus1.wbRd_i       = bus0.wbRd_i;
  assign bus1.wbData_i     = bus0.wbData_i;

  always #5 clk = ~clk;

  // Model of what the EX/MEM register should hold.
  logic        m_start, m_rw, m_mtr, m_mr, m_mw;
  logic [31:0] m_res, m_wd;
  logic [4:0]  m_rd;

  task automatic model_reset();
    m_start = 0; m_rw = 0; m_mtr = 0; m_mr = 0; m_mw = 0;
    m_res = 0; m_wd = 0; m_rd = 0;
  endtask

  function automatic logic [73:0] exp_out();
    return {m_start, m_rw, m_mtr, m_mr, m_mw, m_rd, m_res, m_wd};
  endfunction

  function automatic logic [73:0] dut_out();
    return {bus0.start_o, bus0.RegWrite_o, bus0.MemtoReg_o, bus0.MemRead_o, bus0.MemWrite_o,
            bus0.rd_o, bus0.ALUResult_o, bus0.memWriteData_o};
  endfunction

  // Which stage supplies the newest value of register rs.
  function automatic logic [1:0] ref_fwd(input logic [4:0] rs);
    if (m_rw && m_rd != 5'd0 && m_rd == rs) return 2'b10;
    if (bus0.wbRegWrite_i && bus0.wbRd_i != 5'd0 && bus0.wbRd_i == rs) return 2'b01;
    return 2'b00;
  endfunction

  function automatic logic [31:0] ref_operand(input logic [4:0] rs, input logic [31:0] rf);
    logic [1:0] src;
    src = ref_fwd(rs);
    if (src == 2'b10) return m_res;
    if (src == 2'b01) return bus0.wbData_i;
    return rf;
  endfunction

  function automatic logic [31:0] ref_alu(input logic [1:0] op, input logic [9:0] f,
                                          input logic [31:0] a, input logic [31:0] b,
                                          input logic [31:0] imm);
    logic [63:0] prod;
    logic [31:0] r;
    if (op == 2'b00) return a + b;
    if (op == 2'b01) return a - b;
    if (op == 2'b10) begin
      if (f == 10'b0000000_111) return a & b;
      if (f == 10'b0000000_100) return a ^ b;
      if (f == 10'b0000000_001) return a * (32'd1 << b[4:0]);
      if (f == 10'b0000000_000) return a + b;
      if (f == 10'b0100000_000) return a - b;
      if (f == 10'b0000001_000) begin
        prod = {32'd0, a} * {32'd0, b};
        return prod[31:0];
      end
      return 32'd0;
    end
    if (f[2:0] == 3'b000) return a + b;
    if (f[2:0] == 3'b101) begin
      r = a;
      for (int i = 0; i < int'(imm[4:0]); i++) r = {r[31], r[31:1]};
      return r;
    end
    return 32'd0;
  endfunction

  // Advance one clock, updating the model from the inputs present before the edge.
  task automatic tick();
    logic [31:0] a, bsrc, res;
    a    = ref_operand(bus0.rs1_i, bus0.reg1Data_i);
    bsrc = ref_operand(bus0.rs2_i, bus0.reg2Data_i);
    res  = ref_alu(bus0.ALUOp_i, bus0.funct_i, a, bus0.ALUSrc_i ? bus0.imm_i : bsrc, bus0.imm_i);
    @(posedge clk);
    if (bus0.start_i) begin
      m_start = 1; m_rw = bus0.RegWrite_i; m_mtr = bus0.MemtoReg_i;
      m_mr = bus0.MemRead_i; m_mw = bus0.MemWrite_i;
      m_res = res; m_wd = bsrc; m_rd = bus0.rd_i;
    end
    #1;
  endtask

  task automatic clear_inputs();
    bus0.start_i = 1; bus0.RegWrite_i = 0; bus0.MemtoReg_i = 0; bus0.MemRead_i = 0;
    bus0.MemWrite_i = 0; bus0.ALUSrc_i = 0; bus0.ALUOp_i = 0;
    bus0.reg1Data_i = 0; bus0.reg2Data_i = 0; bus0.rs1_i = 0; bus0.rs2_i = 0; bus0.rd_i = 0;
    bus0.funct_i = 0; bus0.imm_i = 0;
    bus0.wbRegWrite_i = 0; bus0.wbRd_i = 0; bus0.wbData_i = 0;
  endtask

  task automatic bubble();
    clear_inputs();
    tick();
  endtask

  task automatic test_reset();
    tests_run++;
    if (dut_out() !== 74'd0 || bus0.fwdA_o !== 2'b00 || bus0.fwdB_o !== 2'b00) begin
      tests_failed++;
      $display("FAIL reset_initial: got out=%h fwd=%b/%b, want all 0", dut_out(), bus0.fwdA_o, bus0.fwdB_o);
    end
    @(negedge clk); rst = 0;
    clear_inputs();
    bus0.RegWrite_i = 1; bus0.MemWrite_i = 1; bus0.ALUOp_i = 2'b10;
    bus0.reg1Data_i = 5; bus0.reg2Data_i = 7; bus0.rs1_i = 1; bus0.rs2_i = 2; bus0.rd_i = 9;
    tick();
    tests_run++;
    if (dut_out() !== exp_out()) begin
      tests_failed++;
      $display("FAIL reset_preload: got %h want %h", dut_out(), exp_out());
    end
    bus0.rs1_i = 9;
    #1;
    tests_run++;
    if (bus0.fwdA_o !== 2'b10) begin
      tests_failed++;
      $display("FAIL reset_prefwd: got %b want 10", bus0.fwdA_o);
    end
    #1 rst = 1;
    #1;
    tests_run++;
    if (dut_out() !== 74'd0 || bus0.fwdA_o !== 2'b00) begin
      tests_failed++;
      $display("FAIL reset_async: got out=%h fwdA=%b, want 0/00", dut_out(), bus0.fwdA_o);
    end
    @(negedge clk); rst = 0;
    model_reset();
    $display("[TB] reset: async clear checked");
  endtask

  task automatic test_rtype_add();
    bubble();
    bus0.reg1Data_i = 5; bus0.reg2Data_i = 7; bus0.rs1_i = 1; bus0.rs2_i = 2;
    bus0.ALUOp_i = 2'b10; bus0.funct_i = 10'b0000000_000; bus0.rd_i = 5; bus0.RegWrite_i = 1;
    #1;
    tests_run++;
    if (bus0.fwdA_o !== 2'b00 || bus0.fwdB_o !== 2'b00) begin
      tests_failed++;
      $display("FAIL add_fwd: got %b/%b want 00/00", bus0.fwdA_o, bus0.fwdB_o);
    end
    tick();
    tests_run++;
    if (bus0.ALUResult_o !== 32'd12 || bus0.rd_o !== 5'd5 || bus0.start_o !== 1'b1) begin
      tests_failed++;
      $display("FAIL add_result: got res=%0d rd=%0d start=%b want 12/5/1",
               bus0.ALUResult_o, bus0.rd_o, bus0.start_o);
    end
    $display("[TB] rtype add: 5 + 7 -> %0d", bus0.ALUResult_o);
  endtask

  task automatic test_back_to_back();
    for (int p = 0; p < 2; p++) begin
      bubble();
      bus0.RegWrite_i = 1; bus0.ALUOp_i = 2'b10; bus0.funct_i = 10'b0000000_000;
      bus0.reg1Data_i = 2; bus0.reg2Data_i = 3; bus0.rs1_i = 1; bus0.rs2_i = 2; bus0.rd_i = 3;
      tick();
      bus0.ALUOp_i = 2'b01; bus0.rs1_i = 3; bus0.reg1Data_i = 99;
      bus0.rs2_i = 6; bus0.reg2Data_i = 1; bus0.rd_i = 7;
      if (p == 1) begin
        bus0.wbRegWrite_i = 1; bus0.wbRd_i = 3; bus0.wbData_i = 50;
      end
      #1;
      tests_run++;
      if (bus0.fwdA_o !== 2'b10) begin
        tests_failed++;
        $display("FAIL b2b_fwdA[%0d]: got %b want 10", p, bus0.fwdA_o);
      end
      tick();
      tests_run++;
      if (bus0.ALUResult_o !== 32'd4) begin
        tests_failed++;
        $display("FAIL b2b_result[%0d]: got %0d want 4", p, bus0.ALUResult_o);
      end
      $display("[TB] back-to-back pass %0d: result %0d", p, bus0.ALUResult_o);
    end
  endtask

  task automatic test_wb_store();
    bubble();
    bus0.MemWrite_i = 1; bus0.ALUSrc_i = 1; bus0.imm_i = 8; bus0.ALUOp_i = 2'b00;
    bus0.rs1_i = 1; bus0.reg1Data_i = 32'h100; bus0.rs2_i = 4; bus0.reg2Data_i = 32'h1111;
    bus0.wbRegWrite_i = 1; bus0.wbRd_i = 4; bus0.wbData_i = 32'hDEADBEEF;
    #1;
    tests_run++;
    if (bus0.fwdB_o !== 2'b01 || bus0.fwdA_o !== 2'b00) begin
      tests_failed++;
      $display("FAIL store_fwd: got %b/%b want 00/01", bus0.fwdA_o, bus0.fwdB_o);
    end
    tick();
    tests_run++;
    if (bus0.ALUResult_o !== 32'h108 || bus0.memWriteData_o !== 32'hDEADBEEF ||
        bus0.MemWrite_o !== 1'b1) begin
      tests_failed++;
      $display("FAIL store_out: got addr=%h data=%h mw=%b want 108/deadbeef/1",
               bus0.ALUResult_o, bus0.memWriteData_o, bus0.MemWrite_o);
    end
    $display("[TB] wb store: addr %h data %h", bus0.ALUResult_o, bus0.memWriteData_o);
  endtask

  task automatic test_edges();
    bubble();
    bus0.ALUOp_i = 2'b11; bus0.funct_i = 10'b0100000_101; bus0.ALUSrc_i = 1;
    bus0.reg1Data_i = 32'h80000000; bus0.rs1_i = 1; bus0.imm_i = 4;
    tick();
    tests_run++;
    if (bus0.ALUResult_o !== 32'hF8000000) begin
      tests_failed++;
      $display("FAIL srai: got %h want f8000000", bus0.ALUResult_o);
    end
    bubble();
    bus0.ALUOp_i = 2'b10; bus0.funct_i = 10'b0000001_000;
    bus0.reg1Data_i = 32'h10000; bus0.reg2Data_i = 32'h10000; bus0.rs1_i = 1; bus0.rs2_i = 2;
    bus0.rd_i = 1;
    tick();
    tests_run++;
    if (bus0.ALUResult_o !== 32'd0 || bus0.rd_o !== 5'd1) begin
      tests_failed++;
      $display("FAIL mul_wrap: got %h rd=%0d want 0 rd=1", bus0.ALUResult_o, bus0.rd_o);
    end
    bubble();
    bus0.ALUOp_i = 2'b10; bus0.funct_i = 10'b0000000_000;
    bus0.reg1Data_i = 32'hFFFFFFFF; bus0.reg2Data_i = 1; bus0.rs1_i = 1; bus0.rs2_i = 2;
    tick();
    tests_run++;
    if (bus0.ALUResult_o !== 32'd0) begin
      tests_failed++;
      $display("FAIL add_wrap: got %h want 0", bus0.ALUResult_o);
    end
    bubble();
    bus0.RegWrite_i = 1; bus0.rd_i = 0; bus0.reg1Data_i = 123; bus0.rs1_i = 1;
    tick();
    bus0.rs1_i = 0; bus0.rs2_i = 0; bus0.reg1Data_i = 0; bus0.reg2Data_i = 0;
    bus0.wbRegWrite_i = 1; bus0.wbRd_i = 0; bus0.wbData_i = 32'h55;
    #1;
    tests_run++;
    if (bus0.fwdA_o !== 2'b00 || bus0.fwdB_o !== 2'b00) begin
      tests_failed++;
      $display("FAIL x0_nofwd: got %b/%b want 00/00", bus0.fwdA_o, bus0.fwdB_o);
    end
    tick();
    $display("[TB] edges: srai/mul/add wrap/x0 done");
  endtask

  task automatic test_stall();
    logic [73:0] held;
    bubble();
    bus0.RegWrite_i = 1; bus0.ALUOp_i = 2'b00; bus0.reg1Data_i = 10; bus0.reg2Data_i = 20;
    bus0.rs1_i = 1; bus0.rs2_i = 2; bus0.rd_i = 2;
    tick();
    held = {1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 5'd2, 32'd30, 32'd20};
    for (int c = 0; c < 3; c++) begin
      bus0.start_i = 0; bus0.reg1Data_i = $urandom; bus0.reg2Data_i = $urandom;
      bus0.rd_i = 5'($urandom_range(1, 31)); bus0.MemRead_i = 1; bus0.ALUOp_i = 2'($urandom);
      tick();
      tests_run++;
      if (dut_out() !== held) begin
        tests_failed++;
        $display("FAIL stall_hold[%0d]: got %h want %h", c, dut_out(), held);
      end
    end
    clear_inputs();
    bus0.reg1Data_i = 1; bus0.reg2Data_i = 1; bus0.rs1_i = 5; bus0.rs2_i = 6; bus0.rd_i = 4;
    tick();
    tests_run++;
    if (bus0.ALUResult_o !== 32'd2 || bus0.rd_o !== 5'd4) begin
      tests_failed++;
      $display("FAIL stall_resume: got %0d rd=%0d want 2 rd=4", bus0.ALUResult_o, bus0.rd_o);
    end
    $display("[TB] stall: held 3 cycles, resumed with %0d", bus0.ALUResult_o);
  endtask

  task automatic test_random();
    logic [9:0] functs [8];
    logic [1:0] efa, efb;
    functs = '{10'b0000000_111, 10'b0000000_100, 10'b0000000_001, 10'b0000000_000,
               10'b0100000_000, 10'b0000001_000, 10'b0100000_101, 10'b0000000_110};
    for (int n = 0; n < 60; n++) begin
      bus0.start_i    = ($urandom_range(0, 7) != 0);
      bus0.RegWrite_i = 1'($urandom); bus0.MemtoReg_i = 1'($urandom);
      bus0.MemRead_i  = 1'($urandom); bus0.MemWrite_i = 1'($urandom);
      bus0.ALUSrc_i   = 1'($urandom); bus0.ALUOp_i = 2'($urandom);
      bus0.funct_i    = ($urandom_range(0, 9) == 0) ? 10'($urandom) : functs[$urandom_range(0, 7)];
      bus0.reg1Data_i = $urandom; bus0.reg2Data_i = $urandom; bus0.imm_i = $urandom;
      bus0.rs1_i = 5'($urandom_range(0, 3)); bus0.rs2_i = 5'($urandom_range(0, 3));
      bus0.rd_i  = 5'($urandom_range(0, 3));
      bus0.wbRegWrite_i = 1'($urandom); bus0.wbRd_i = 5'($urandom_range(0, 3));
      bus0.wbData_i = $urandom;
      #1;
      efa = ref_fwd(bus0.rs1_i);
      efb = ref_fwd(bus0.rs2_i);
      tests_run++;
      if ({bus0.fwdA_o, bus0.fwdB_o} !== {efa, efb}) begin
        tests_failed++;
        $display("FAIL rand_fwd[%0d]: got %b/%b want %b/%b", n, bus0.fwdA_o, bus0.fwdB_o, efa, efb);
      end
      tests_run++;
      if ({bus1.fwdA_o, bus1.fwdB_o} !== 4'b0000) begin
        tests_failed++;
        $display("FAIL nofwd_sel[%0d]: got %b/%b want 00/00", n, bus1.fwdA_o, bus1.fwdB_o);
      end
      tick();
      tests_run++;
      if (dut_out() !== exp_out()) begin
        tests_failed++;
        $display("FAIL rand_out[%0d]: got %h want %h", n, dut_out(), exp_out());
      end
      $display("[TB] rand %0d op=%b funct=%b fwd=%b/%b res=%h", n, bus0.ALUOp_i, bus0.funct_i,
               efa, efb, bus0.ALUResult_o);
    end
  endtask

  initial begin
    tests_run = 0;
    tests_failed = 0;
    clk = 0;
    rst = 1;
    model_reset();
    clear_inputs();
    repeat (2) @(posedge clk);
    #1;
    test_reset();
    test_rtype_add();
    test_back_to_back();
    test_wb_store();
    test_edges();
    test_stall();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end
endmodule

// File: doc/ex_stage.md
Name: ex_stage

Overview:
- Execute stage of the 5-stage RISC-V pipeline. Sits directly downstream of the ID/EX pipeline register and consumes its outputs.
- Contains operand forwarding, ALU-control decode and the 32-bit ALU, and owns the EX/MEM pipeline register.
- Its registered outputs feed the data-memory stage and serve as its own MEM-stage forwarding source.

Parameters:
- FWD_EN, 1, 1 = forwarding enabled; 0 = operands always taken from reg1Data_i/reg2Data_i.

Ports:
- clk_i  in  1  clock
- rst_i  in  1  reset, asynchronous, active-high
- start_i  in  1  pipeline enable; EX/MEM register updates only when 1
- RegWrite_i, MemtoReg_i, MemRead_i, MemWrite_i, ALUSrc_i  in  1 each  control from ID/EX
- ALUOp_i  in  2  00 = load/store, 01 = branch, 10 = R-type, 11 = I-type ALU
- reg1Data_i, reg2Data_i  in  32 each  register-file read data
- rs1_i, rs2_i, rd_i  in  5 each  register IDs
- funct_i  in  10  {funct7, funct3}
- imm_i  in  32  sign-extended immediate
- wbRegWrite_i  in  1  WB-stage write enable
- wbRd_i  in  5  WB-stage destination
- wbData_i  in  32  WB-stage write-back data
- start_o  out  1  registered start_i
- RegWrite_o, MemtoReg_o, MemRead_o, MemWrite_o  out  1 each  registered control
- ALUResult_o  out  32  registered ALU result
- memWriteData_o  out  32  registered store data (forwarded operand B)
- rd_o  out  5  registered destination
- fwdA_o, fwdB_o  out  2 each  combinational select: 00 = regfile, 10 = EX/MEM, 01 = WB

Behaviour:
- Reset (async, any time, including mid-stream): every registered output = 0 immediately; fwdA_o/fwdB_o follow from the zeroed state.
- Forward select A (B is identical, using rs2_i):
  - 10 if FWD_EN && RegWrite_o && rd_o != 0 && rd_o == rs1_i
  - else 01 if FWD_EN && wbRegWrite_i && wbRd_i != 0 && wbRd_i == rs1_i
  - else 00
  - EX/MEM has priority when both stages match.
- Forwarded values: opA = selected value; fwdB = selected value. Sources: EX/MEM source = ALUResult_o; WB source = wbData_i.
- opB = ALUSrc_i ? imm_i : fwdB.
- Load-use hazards are removed upstream by a NoOp bubble; this block does not check MemtoReg_o when forwarding.
- ALU (combinational, 32-bit, wrap-around, no flags):
  - ALUOp 00: add
  - ALUOp 01: sub
  - ALUOp 10 (decoded on funct_i):
    - 0000000_111 and
    - 0000000_100 xor
    - 0000000_001 sll by opB[4:0]
    - 0000000_000 add
    - 0100000_000 sub
    - 0000001_000 mul, low 32 bits of the product
  - ALUOp 11 (decoded on funct3):
    - 000 addi
    - 101 srai: arithmetic shift right of opA by imm_i[4:0]
  - Any other encoding: result 0.
- Register update (posedge clk_i, rst_i low, start_i == 1):
  - control outputs <= inputs
  - ALUResult_o <= ALU result
  - memWriteData_o <= fwdB
  - rd_o <= rd_i
  - start_o <= 1
- start_i == 0: all registered outputs hold their values.
- Latency: exactly 1 cycle from ID/EX outputs to EX/MEM outputs.
- Bubble: all-zero control in yields RegWrite_o = 0 next cycle, so it never forwards.
- rd = x0: never forwards, even when RegWrite is set.

Test Plan:
- Reset: assert rst_i mid-cycle after outputs become non-zero -> all outputs 0 immediately, without waiting for a clock edge.
- R-type add, no hazard: reg1 = 5, reg2 = 7, ALUOp = 10, funct = 0000000_000, start = 1 -> next edge ALUResult_o = 12, fwdA_o = fwdB_o = 00.
- Back-to-back dependency:
  - Cycle 1: x3 = 2 + 3 (RegWrite = 1, rd = 3).
  - Cycle 2: sub with rs1 = 3, reg1Data_i = stale 99, reg2 = 1.
  - Required: fwdA_o = 10 and ALUResult_o = 4.
  - Same sequence with wbRegWrite_i = 1, wbRd_i = 3, wbData_i = 50 driven together -> EX/MEM still wins, result 4.
- WB forward plus store data:
  - Inputs: sw with rs2 = 4, wbRegWrite_i = 1, wbRd_i = 4, wbData_i = 0xDEADBEEF, ALUSrc = 1, imm = 8, reg1 = 0x100.
  - Required: ALUResult_o = 0x108, memWriteData_o = 0xDEADBEEF, fwdB_o = 01.
- Arithmetic and edge values:
  - srai: opA = 0x80000000, imm = 4 -> 0xF8000000.
  - mul: 0x10000 * 0x10000 -> 0.
  - add: 0xFFFFFFFF + 1 -> 0.
  - rd = x0 writer followed by a reader of x0 -> fwdA_o = 00.
- Stall/hold: start_i = 0 for 3 cycles while inputs change -> outputs unchanged. start_i = 1 -> new result after 1 edge. FWD_EN = 0 build -> fwd selects always 00.
